// File: rtl/if_fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, drives the instruction-memory
// address and buffers fetched words in an in-order queue toward decode.
module if_fetch_ctrl #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int unsigned QDEPTH       = 2,
  parameter bit          WORD_ADDR    = 1'b1,
  parameter logic [31:0] EBREAK_INSTR = 32'h0010_0073
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic        halted,
  output logic [31:0] fetch_count
);

  localparam int unsigned PW = $clog2(QDEPTH);
  localparam logic [PW:0] CNT_FULL = (PW+1)'(QDEPTH);

  typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

  state_t        state, state_nxt;
  logic [31:0]   pc;
  logic [31:0]   q_instr [QDEPTH];
  logic [31:0]   q_pc    [QDEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [PW:0]   count;
  logic          push, pop;

  // Redirect suppresses both push and pop; it only flushes and retargets.
  always_comb begin
    state_nxt = state;
    push      = 1'b0;
    pop       = (count != '0) && out_ready && !redirect_valid;
    if (redirect_valid) begin
      state_nxt = run ? RUN : IDLE;
    end else begin
      case (state)
        IDLE: if (run) state_nxt = RUN;
        RUN: begin
          if (!run) begin
            state_nxt = IDLE;
          end else begin
            push = (count < CNT_FULL) || pop;
            if (push && (imem_instr == EBREAK_INSTR)) state_nxt = HALT;
          end
        end
        HALT:    state_nxt = HALT;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc          <= RESET_PC;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      fetch_count <= '0;
      for (int unsigned i = 0; i < QDEPTH; i++) begin
        q_instr[i] <= '0;
        q_pc[i]    <= '0;
      end
    end else if (redirect_valid) begin
      pc     <= {redirect_pc[31:2], 2'b00};
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        q_instr[wr_ptr] <= imem_instr;
        q_pc[wr_ptr]    <= pc;
        wr_ptr          <= wr_ptr + 1'b1;
        pc              <= pc + 32'd4;
        fetch_count     <= fetch_count + 32'd1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign imem_addr = WORD_ADDR ? {2'b00, pc[31:2]} : pc;
  assign out_valid = (count != '0);
  assign out_instr = q_instr[rd_ptr];
  assign out_pc    = q_pc[rd_ptr];
  assign halted    = (state == HALT) && (count == '0);

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Randomized bench for if_fetch_ctrl: a queue-based reference model feeds a
// scoreboard that a separate monitor checks against the DUT every cycle.
module tb_if_fetch_ctrl;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int unsigned QDEPTH   = 2;
  localparam logic [31:0] EBREAK   = 32'h0010_0073;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        run = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        halted;
  logic [31:0] fetch_count;

  logic [31:0] rom [64];

  int unsigned checks = 0;
  int unsigned errors = 0;

  // reference model state: mode 0=stopped,1=fetching,2=halted
  entry_t      sb[$];
  int          mode = 0;
  logic [31:0] mpc = RESET_PC;
  logic [31:0] mfc = '0;
  bit          last_rst = 1'b1;

  always #5 clk = ~clk;

  assign imem_instr = rom[imem_addr[5:0]];

  if_fetch_ctrl #(
    .RESET_PC(RESET_PC),
    .QDEPTH(QDEPTH),
    .WORD_ADDR(1'b1),
    .EBREAK_INSTR(EBREAK)
  ) dut (
    .clk(clk),
    .rst(rst),
    .run(run),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .imem_addr(imem_addr),
    .imem_instr(imem_instr),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_instr(out_instr),
    .out_pc(out_pc),
    .halted(halted),
    .fetch_count(fetch_count)
  );

  // Reference model: advances from the inputs driven since the last negedge.
  always @(posedge clk) begin
    bit     do_pop, do_push;
    entry_t e;
    last_rst = rst;
    if (rst) begin
      sb.delete();
      mpc  = RESET_PC;
      mode = 0;
      mfc  = '0;
    end else if (redirect_valid) begin
      sb.delete();
      mpc  = redirect_pc & 32'hFFFF_FFFC;
      mode = run ? 1 : 0;
    end else begin
      do_pop  = (sb.size() != 0) && out_ready;
      do_push = (mode == 1) && run && ((sb.size() < QDEPTH) || do_pop);
      if (do_pop) void'(sb.pop_front());
      if (do_push) begin
        e.pc    = mpc;
        e.instr = rom[(mpc >> 2) & 32'd63];
        sb.push_back(e);
        mpc = mpc + 32'd4;
        mfc = mfc + 32'd1;
        if (e.instr == EBREAK) mode = 2;
      end else if (mode == 0 && run) begin
        mode = 1;
      end else if (mode == 1 && !run) begin
        mode = 0;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got=%h exp=%h", name, $time, got, exp);
    end
  endtask

  // Monitor: compares the presented head and status against the scoreboard.
  always @(posedge clk) begin
    #1;
    chk("out_valid", {31'd0, out_valid}, {31'd0, sb.size() != 0});
    if (out_valid && sb.size() != 0) begin
      chk("out_pc", out_pc, sb[0].pc);
      chk("out_instr", out_instr, sb[0].instr);
    end
    if (last_rst) begin
      chk("rst_out_pc", out_pc, 32'd0);
      chk("rst_out_instr", out_instr, 32'd0);
    end
    chk("imem_addr", imem_addr, mpc >> 2);
    chk("halted", {31'd0, halted}, {31'd0, (mode == 2) && (sb.size() == 0)});
    chk("fetch_count", fetch_count, mfc);
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) rom[i] = 32'h1000_0000 | i;
    rst = 1'b1;
    step(2);
    // straight-line fetch
    rst = 1'b0; run = 1'b1; out_ready = 1'b1;
    step(12);
    // backpressure then release
    rst = 1'b1; step(1); rst = 1'b0;
    out_ready = 1'b0;
    step(7);
    out_ready = 1'b1;
    step(6);
    // redirect on a full queue with pop and push also requested
    out_ready = 1'b0;
    step(4);
    out_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h0000_0043;
    step(1);
    redirect_valid = 1'b0;
    step(6);
    // EBREAK halts fetch
    rom[3] = EBREAK;
    rst = 1'b1; step(1); rst = 1'b0;
    step(15);
    // redirect out of HALT
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0020;
    step(1);
    redirect_valid = 1'b0;
    step(5);
    // reset mid-run colliding with a redirect
    out_ready = 1'b0;
    step(3);
    rst = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h0000_0080;
    step(1);
    rst = 1'b0; redirect_valid = 1'b0; out_ready = 1'b1;
    step(6);
    // randomized traffic
    for (int i = 0; i < 64; i++)
      rom[i] = ($urandom_range(0, 11) == 0) ? EBREAK : $urandom;
    for (int c = 0; c < 600; c++) begin
      run            = ($urandom_range(0, 9) != 0);
      out_ready      = ($urandom_range(0, 2) != 0);
      redirect_valid = ($urandom_range(0, 14) == 0);
      redirect_pc    = $urandom_range(0, 255);
      rst            = ($urandom_range(0, 199) == 0);
      step(1);
    end
    rst = 1'b0; redirect_valid = 1'b0;
    step(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
